// File: rtl/svc_rst_seq.sv
// Sequenced reset controller: holds every downstream domain in reset, then
// releases them one at a time in index order, each gated by its acknowledge.
module svc_rst_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  done,
  output logic                  busy,
  output logic [NUM_STAGES-1:0] err
);

  localparam int HG_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (HG_MAX > ACK_TIMEOUT) ? HG_MAX : ACK_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_ACK,
    S_GAP,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   rst_out_q, rst_out_d;
  logic                    done_q, done_d;
  logic [NUM_STAGES-1:0]   err_q, err_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    err_d     = err_q;

    if (soft_rst_req) begin
      state_d   = S_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
      err_d     = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            idx_d        = '0;
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            state_d      = S_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_ACK: begin
          // Only the stage currently being released is listened to.
          if (stage_ack[idx_q]) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else if (cnt_q == ACK_LAST) begin
            err_d[idx_q] = 1'b1;
            cnt_d        = '0;
            state_d      = S_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            if (idx_q == IDX_LAST) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              idx_d            = idx_q + IDX_W'(1);
              rst_out_d[idx_d] = 1'b0;
              cnt_d            = '0;
              state_d          = S_WAIT_ACK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so all of them update together.
    if (rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rst_out = rst_out_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != S_DONE);

endmodule

// File: tb/tb_svc_rst_seq.sv
// Self-checking bench for svc_rst_seq: directed timing scenarios plus a
// randomized run against a timestamp-based reference model.
module tb_svc_rst_seq;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int TO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         soft_rst_req = 1'b0;
  logic [N-1:0] stage_ack = '0;
  logic [N-1:0] rst_out, err;
  logic         done, busy;

  logic         rst1 = 1'b1;
  logic         soft1 = 1'b0;
  logic [0:0]   ack1 = '0;
  logic [0:0]   rst_out1, err1;
  logic         done1, busy1;

  svc_rst_seq dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req), .stage_ack(stage_ack),
    .rst_out(rst_out), .done(done), .busy(busy), .err(err)
  );

  svc_rst_seq #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .ACK_TIMEOUT(1)) dut1 (
    .clk(clk), .rst(rst1), .soft_rst_req(soft1), .stage_ack(ack1),
    .rst_out(rst_out1), .done(done1), .busy(busy1), .err(err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: absolute edge timestamps for release, wait start and gap end.
  logic [N-1:0] m_rst = '1;
  logic [N-1:0] m_err = '0;
  logic         m_done = 1'b0;
  int           m_cur = 0;
  int           m_rel_at = -1;
  int           m_wait_start = 0;
  int           m_gap_end = -1;
  bit           m_waiting = 1'b0;

  task automatic model_release_cur();
    m_rst[m_cur] = 1'b0;
    m_waiting    = 1'b1;
    m_wait_start = cyc;
  endtask

  task automatic model_step();
    if (rst || soft_rst_req) begin
      m_rst = '1; m_err = '0; m_done = 1'b0; m_cur = 0;
      m_rel_at = cyc + HOLD; m_waiting = 1'b0; m_gap_end = -1;
    end else if (!m_done) begin
      if (cyc == m_rel_at) begin
        model_release_cur();
      end else if (m_waiting) begin
        if (stage_ack[m_cur]) begin
          m_waiting = 1'b0; m_gap_end = cyc + GAP;
        end else if (cyc - m_wait_start == TO) begin
          m_err[m_cur] = 1'b1; m_waiting = 1'b0; m_gap_end = cyc + GAP;
        end
      end else if (cyc == m_gap_end) begin
        if (m_cur == N - 1) m_done = 1'b1;
        else begin
          m_cur = m_cur + 1;
          model_release_cur();
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
  endtask

  // Edge-relative event recording for the directed scenarios.
  int           t0;
  int           fall_e[N];
  int           done_e, err_e, mm;
  logic [N-1:0] prev_rst;
  logic         prev_done;

  task automatic track_start();
    t0 = cyc;
    for (int i = 0; i < N; i++) fall_e[i] = -1;
    done_e = -1; err_e = -1; mm = 0;
    prev_rst = rst_out; prev_done = done;
  endtask

  task automatic run_edges(input int n);
    for (int k = 0; k < n; k++) begin
      cycle();
      for (int i = 0; i < N; i++)
        if (prev_rst[i] && !rst_out[i]) fall_e[i] = cyc - t0;
      if (done && !prev_done) done_e = cyc - t0;
      if (err != '0 && err_e < 0) err_e = cyc - t0;
      if ({rst_out, done, busy, err} !== {m_rst, m_done, !m_done, m_err}) begin
        mm++;
        if (mm == 1)
          $display("model divergence at edge %0d: dut %b model %b", cyc - t0,
                   {rst_out, done, busy, err}, {m_rst, m_done, !m_done, m_err});
      end
      prev_rst = rst_out; prev_done = done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1;
    cycle(); cycle();
    checks++;
    if ({rst_out, done, busy, err} !== {3'b111, 1'b0, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got %b want %b", {rst_out, done, busy, err}, 8'b1110_1000);
    end
    checks++;
    if ({rst_out1, done1, busy1, err1} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_state_min got %b want %b", {rst_out1, done1, busy1, err1}, 4'b1010);
    end
  endtask

  task automatic test_nominal();
    int exp_f[N] = '{4, 7, 10};
    rst = 1'b1; stage_ack = 3'b111;
    cycle();
    track_start(); rst = 1'b0;
    run_edges(14);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (fall_e[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL nominal_fall%0d got e%0d want e%0d", i, fall_e[i], exp_f[i]);
      end
    end
    checks++;
    if (done_e !== 13 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done got e%0d busy %b want e13 busy 0", done_e, busy);
    end
    checks++;
    if (mm !== 0) begin errors++; $display("FAIL nominal_model got %0d diffs want 0", mm); end
  endtask

  task automatic test_timeout();
    int exp_f[N] = '{4, 7, 17};
    rst = 1'b1; stage_ack = 3'b101;
    cycle();
    track_start(); rst = 1'b0;
    run_edges(21);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (fall_e[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL timeout_fall%0d got e%0d want e%0d", i, fall_e[i], exp_f[i]);
      end
    end
    checks++;
    if (err_e !== 15 || err !== 3'b010) begin
      errors++;
      $display("FAIL timeout_err got e%0d err %b want e15 err 010", err_e, err);
    end
    checks++;
    if (done_e !== 20) begin errors++; $display("FAIL timeout_done got e%0d want e20", done_e); end
    checks++;
    if (mm !== 0) begin errors++; $display("FAIL timeout_model got %0d diffs want 0", mm); end
  endtask

  task automatic test_soft();
    int exp_f[N] = '{4, 7, 10};
    stage_ack = 3'b111; soft_rst_req = 1'b1;
    cycle();
    checks++;
    if ({rst_out, done, busy, err} !== {3'b111, 1'b0, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL soft_pulse got %b want %b", {rst_out, done, busy, err}, 8'b1110_1000);
    end
    track_start(); soft_rst_req = 1'b0;
    run_edges(14);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (fall_e[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL soft_fall%0d got e%0d want e%0d", i, fall_e[i], exp_f[i]);
      end
    end
    checks++;
    if (done_e !== 13) begin errors++; $display("FAIL soft_done got e%0d want e13", done_e); end
    soft_rst_req = 1'b1;
    run_edges(3);
    checks++;
    if ({rst_out, busy} !== 4'b1111) begin
      errors++;
      $display("FAIL soft_held got %b want 1111", {rst_out, busy});
    end
    track_start(); soft_rst_req = 1'b0;
    run_edges(5);
    checks++;
    if (fall_e[0] !== 4) begin
      errors++;
      $display("FAIL soft_held_release got e%0d want e4", fall_e[0]);
    end
    checks++;
    if (mm !== 0) begin errors++; $display("FAIL soft_model got %0d diffs want 0", mm); end
  endtask

  task automatic test_early_ack();
    int exp_f[N] = '{4, 14, 17};
    rst = 1'b1; stage_ack = 3'b100;
    cycle();
    track_start(); rst = 1'b0;
    run_edges(11);
    stage_ack = 3'b111;
    run_edges(9);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (fall_e[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL early_fall%0d got e%0d want e%0d", i, fall_e[i], exp_f[i]);
      end
    end
    checks++;
    if (err !== 3'b000 || done_e !== 20) begin
      errors++;
      $display("FAIL early_end got err %b done e%0d want err 000 done e20", err, done_e);
    end
  endtask

  task automatic test_mid_rst();
    int exp_f[N] = '{4, 7, 10};
    rst = 1'b1; stage_ack = 3'b111;
    cycle();
    track_start(); rst = 1'b0;
    run_edges(7);
    checks++;
    if (rst_out !== 3'b100) begin errors++; $display("FAIL mid_pre got %b want 100", rst_out); end
    rst = 1'b1;
    cycle();
    checks++;
    if ({rst_out, done, busy, err} !== {3'b111, 1'b0, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL mid_rst got %b want %b", {rst_out, done, busy, err}, 8'b1110_1000);
    end
    track_start(); rst = 1'b0;
    run_edges(14);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (fall_e[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL mid_fall%0d got e%0d want e%0d", i, fall_e[i], exp_f[i]);
      end
    end
    checks++;
    if (done_e !== 13) begin errors++; $display("FAIL mid_done got e%0d want e13", done_e); end
  endtask

  task automatic test_min_cfg();
    // {rst_out, err, done} expected at edges 1..4 after the last reset edge
    logic [2:0] exp_t[4] = '{3'b000, 3'b010, 3'b011, 3'b011};
    ack1 = 1'b0; rst1 = 1'b1;
    cycle();
    rst1 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      cycle();
      checks++;
      if ({rst_out1, err1, done1, busy1} !== {exp_t[e-1], !exp_t[e-1][0]}) begin
        errors++;
        $display("FAIL min_cfg_e%0d got %b want %b", e, {rst_out1, err1, done1, busy1},
                 {exp_t[e-1], !exp_t[e-1][0]});
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1; soft_rst_req = 1'b0;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 800; k++) begin
      stage_ack    = N'($urandom & $urandom);
      soft_rst_req = ($urandom_range(0, 39) == 0);
      rst          = ($urandom_range(0, 149) == 0);
      cycle();
      checks++;
      if ({rst_out, done, busy, err} !== {m_rst, m_done, !m_done, m_err}) begin
        errors++;
        $display("FAIL random_c%0d got %b want %b", k, {rst_out, done, busy, err},
                 {m_rst, m_done, !m_done, m_err});
      end
    end
    rst = 1'b0; soft_rst_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_soft();
    test_early_ack();
    test_mid_rst();
    test_min_cfg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
